// File: rtl/fetch_stage.sv
// MIPS fetch stage: owns the PC, drives the instruction memory and holds the IF/ID register.
// Optional performance counters are enabled with FETCH_PERF_COUNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc4,
    output logic               halted
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
    output logic [31:0]        perf_flush
`endif
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    ifid_t       ifid;
    logic        do_redirect, do_capture;
    logic        unused_tgt;

    assign unused_tgt = ^redirect_target[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = halt_req ? HALT : RUN;
            RUN:     if (!redirect_valid && halt_req) state_nxt = HALT;
            HALT:    if (!redirect_valid && !halt_req) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Redirect wins over halt and stall; BOOT ignores everything.
    always_comb begin
        do_redirect = 1'b0;
        do_capture  = 1'b0;
        case (state)
            RUN: begin
                do_redirect = redirect_valid;
                do_capture  = !redirect_valid && !halt_req && (out_ready || !out_valid);
            end
            HALT:    do_redirect = redirect_valid;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            ifid      <= '0;
        end else if (do_redirect) begin
            pc        <= {redirect_target[31:2], 2'b00};
            out_valid <= 1'b0;
        end else if (do_capture) begin
            pc        <= pc + 32'd4;
            out_valid <= 1'b1;
            ifid      <= '{instr: imem_instr, pc: pc, pc4: pc + 32'd4};
        end else begin
            // Halt/stall: the entry only leaves via a decode transfer.
            out_valid <= out_valid & ~out_ready;
        end
    end

    assign imem_addr = pc[IMEM_AW+1:2];
    assign out_instr = ifid.instr;
    assign out_pc    = ifid.pc;
    assign out_pc4   = ifid.pc4;
    assign halted    = (state == HALT) && !out_valid;

`ifdef FETCH_PERF_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (do_capture)
                perf_fetched <= perf_fetched + 32'd1;
            if (state == RUN && out_valid && !out_ready && !redirect_valid)
                perf_stall <= perf_stall + 32'd1;
            if (do_redirect && out_valid && !out_ready)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic          halt_req;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr, out_pc, out_pc4;
    logic          halted;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0]   perf_fetched, perf_stall, perf_flush;
`endif

    logic [31:0] mem [1024];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: 0 = boot, 1 = run, 2 = halt
    int          m_st;
    logic [31:0] m_pc, m_instr, m_opc;
    logic        m_v;
    logic [31:0] m_fe, m_stl, m_fl;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4), .halted(halted)
`ifdef FETCH_PERF_COUNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;
    assign imem_instr = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_v = 1'b0; m_instr = '0; m_opc = '0;
        m_fe = '0; m_stl = '0; m_fl = '0;
    endtask

    task automatic check_all();
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_v});
        chk("imem_addr", {22'b0, imem_addr}, {22'b0, m_pc[AW+1:2]});
        chk("halted", {31'b0, halted}, {31'b0, (m_st == 2) && !m_v});
        if (m_v) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_pc", out_pc, m_opc);
            chk("out_pc4", out_pc4, m_opc + 32'd4);
        end
`ifdef FETCH_PERF_COUNT_EN
        chk("perf_fetched", perf_fetched, m_fe);
        chk("perf_stall", perf_stall, m_stl);
        chk("perf_flush", perf_flush, m_fl);
`endif
    endtask

    // Advance the model by one clock with the currently driven inputs, then compare.
    task automatic step();
        int          n_st = m_st;
        logic [31:0] n_pc = m_pc, n_instr = m_instr, n_opc = m_opc;
        logic        n_v = m_v;
        logic        xfer = m_v && out_ready;
        if (m_st == 0) begin
            n_st = halt_req ? 2 : 1;
        end else if (redirect_valid) begin
            n_pc = {redirect_target[31:2], 2'b00};
            n_v  = 1'b0;
            if (m_v && !xfer) m_fl++;
        end else if (m_st == 2) begin
            n_v  = m_v && !out_ready;
            n_st = halt_req ? 2 : 1;
        end else begin
            if (m_v && !out_ready) m_stl++;
            if (halt_req) begin
                n_v  = m_v && !out_ready;
                n_st = 2;
            end else if (!m_v || out_ready) begin
                n_instr = mem[m_pc[AW+1:2]];
                n_opc   = m_pc;
                n_pc    = m_pc + 32'd4;
                n_v     = 1'b1;
                m_fe++;
            end
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_pc = n_pc; m_v = n_v; m_instr = n_instr; m_opc = n_opc;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2000_0000 + i;
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        halt_req = 1'b0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset out_instr", out_instr, 32'h0);
        rst = 1'b0;

        // boot cycle then three captures
        step();
        chk("boot valid", {31'b0, out_valid}, 32'h0);
        repeat (3) step();
        chk("pc8", out_pc, 32'h8);
        chk("instr2", out_instr, 32'h2000_0002);
        chk("addr3", {22'b0, imem_addr}, 32'd3);

        out_ready = 1'b0;
        repeat (3) step();
        chk("stall pc", out_pc, 32'h8);
        chk("stall addr", {22'b0, imem_addr}, 32'd3);
        out_ready = 1'b1;
        step();
        chk("release pc", out_pc, 32'hC);

        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0103;
        step();
        chk("flush valid", {31'b0, out_valid}, 32'h0);
        chk("redir addr", {22'b0, imem_addr}, 32'd64);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("redir pc", out_pc, 32'h100);

        out_ready = 1'b0;
        step();
        halt_req = 1'b1;
        repeat (2) step();
        chk("halt pending", {31'b0, halted}, 32'h0);
        out_ready = 1'b1;
        step();
        chk("halted", {31'b0, halted}, 32'h1);
        halt_req = 1'b0;
        repeat (2) step();
        chk("resume pc", out_pc, 32'h104);

        // async reset while an entry is held
        out_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async valid", {31'b0, out_valid}, 32'h0);
        chk("async pc", out_pc, 32'h0);
        chk("async addr", {22'b0, imem_addr}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_all();

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int c = 0; c < 600; c++) begin
            out_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 99) < 7);
            redirect_target = $urandom;
            if ($urandom_range(0, 99) < 6) halt_req = ~halt_req;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into an IF/ID register with a valid/ready handshake toward decode.
- Handles decode stalls, branch/jump redirects and halt.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_AW, 10, instruction memory word-address width (1024 words).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  IMEM_AW  word address to instruction memory, = pc[IMEM_AW+1:2], combinational from PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  32  byte target; bits [1:0] ignored (treated as 0).
- halt_req  input  1  level; while high, no new fetches.
- out_valid  output  1  IF/ID register holds an instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_instr  output  32  fetched instruction.
- out_pc  output  32  byte PC of out_instr.
- out_pc4  output  32  out_pc + 4.
- halted  output  1  in HALT state with IF/ID empty.

Behaviour:
- Reset (async, any state):
  - pc = RESET_PC.
  - out_valid = 0; out_instr, out_pc, out_pc4 = 0; halted = 0.
  - State = BOOT.
- BOOT: one cycle after reset deassert. No capture, PC holds. Next state RUN (or HALT if halt_req = 1).
- RUN, evaluated each rising edge in priority order:
  1. redirect_valid: pc <= {redirect_target[31:2], 2'b00}; out_valid <= 0 (flushes the IF/ID entry even if unconsumed). Redirect beats stall and halt in the same cycle.
  2. halt_req: no capture; pc holds; out_valid <= out_valid & ~out_ready; state <= HALT.
  3. Capture (out_ready = 1 or out_valid = 0): out_instr <= imem_instr; out_pc <= pc; out_pc4 <= pc + 4; out_valid <= 1; pc <= pc + 4.
  4. Stall (out_valid = 1, out_ready = 0): all registers hold; imem_addr stable.
- Throughput and latency:
  - One instruction per cycle when out_ready stays high.
  - Latency from PC to out_valid is 1 cycle.
- HALT:
  - No captures; pc holds; the pending entry drains via out_ready.
  - halted = 1 when state is HALT and out_valid = 0.
  - A redirect in HALT updates pc and clears out_valid, and the state stays HALT.
  - halt_req low: next state RUN; the first capture happens in the following RUN cycle.
- Arithmetic:
  - pc + 4 wraps modulo 2^32.
  - imem_addr wraps naturally within 2^IMEM_AW words. No out-of-range detection.
- Decode's view of the handshake: a transfer occurs when out_valid & out_ready at a rising edge. out_instr, out_pc and out_pc4 are stable while out_valid = 1 and out_ready = 0.
- States are encoded as a 2-bit enum: BOOT, RUN, HALT.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- When defined:
  - Adds outputs perf_fetched (32), perf_stall (32) and perf_flush (32). All reset to 0 and wrap at 2^32.
  - perf_fetched increments on every capture.
  - perf_stall increments on every RUN cycle with out_valid = 1 and out_ready = 0 and no redirect.
  - perf_flush increments on every redirect that discards a valid entry (out_valid = 1 and not transferred that cycle).
- When undefined: these ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then 4 cycles with out_ready = 1, RESET_PC = 0, memory word n = 32'h2000_0000+n -> first cycle is BOOT with out_valid = 0; then out_pc = 0, 4, 8 with out_instr = 32'h2000_0000, 32'h2000_0001, 32'h2000_0002; imem_addr = 0, 1, 2, 3.
- Hold out_ready = 0 for 3 cycles with out_pc = 8 -> out_instr, out_pc and imem_addr = 3 stay constant. Release -> out_pc = 12 next cycle with no duplicate or skip.
- redirect_valid with target 32'h0000_0103 during a stall -> out_valid = 0 next cycle, then out_pc = 32'h100 with imem_addr = 64.
- halt_req = 1 while out_valid = 1 and out_ready = 0 -> halted = 0 until out_ready pulses, then halted = 1. Release halt -> fetch resumes at the held pc.
- Assert rst mid-stream while out_valid = 1 -> all outputs clear immediately (asynchronously), pc = RESET_PC.
- With FETCH_PERF_COUNT_EN, 10 captures, 3 stall cycles and 1 flush -> perf_fetched = 10, perf_stall = 3, perf_flush = 1.
